// File: rtl/average_filter.sv
// Two-tap moving average y[n] = floor((x[n] + x[n-1]) / 2) on a signed, strobe-qualified stream.
// Latency: 2 clocks from the accepting edge of data_in to data_out/o_ce; full one-sample-per-clock throughput.
// No backpressure: every o_ce pulse carries a result that the consumer must take.
module average_filter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         o_ce,
    output logic                         o_sum_ce,
    output logic signed [DATA_WIDTH-1:0] o_last_sample,
    output logic signed [DATA_WIDTH:0]   o_sum_ff
);

    // Stage-1 state: previous accepted sample and the widened pair sum.
    logic signed [DATA_WIDTH-1:0] r_last_sample;
    logic signed [DATA_WIDTH:0]   r_sum_ff;
    logic                         r_sum_ce;

    // Stage-2 state: halved result and its strobe.
    logic signed [DATA_WIDTH-1:0] r_data_out;
    logic                         r_ce;

    // One extra bit of headroom keeps the sum of two full-range samples exact.
    logic signed [DATA_WIDTH:0]   w_data_in_ext;
    logic signed [DATA_WIDTH:0]   w_last_ext;
    logic signed [DATA_WIDTH:0]   w_sum;

    // Arithmetic shift right by one of the sum, keeping the low DATA_WIDTH bits.
    // Dropping bit 0 of a two's complement value rounds toward -inf, and the
    // halved value of a (DATA_WIDTH+1)-bit sum always fits in DATA_WIDTH bits.
    logic signed [DATA_WIDTH-1:0] w_half;

    assign w_data_in_ext = {data_in[DATA_WIDTH-1], data_in};
    assign w_last_ext    = {r_last_sample[DATA_WIDTH-1], r_last_sample};
    assign w_sum         = w_data_in_ext + w_last_ext;
    assign w_half        = r_sum_ff[DATA_WIDTH:1];

    // Stage 1: accept a sample on i_ce, form the pair sum and remember the sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_sample <= '0;
            r_sum_ff      <= '0;
        end else if (i_ce) begin
            r_last_sample <= data_in;
            r_sum_ff      <= w_sum;
        end
    end

    // Stage-1 valid: i_ce delayed by one clock, updated on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum_ce <= 1'b0;
        end else begin
            r_sum_ce <= i_ce;
        end
    end

    // Stage 2: halve the registered sum when stage 1 holds a fresh value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (r_sum_ce) begin
            r_data_out <= w_half;
        end
    end

    // Output valid: stage-1 valid delayed by one clock, updated on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ce <= 1'b0;
        end else begin
            r_ce <= r_sum_ce;
        end
    end

    assign data_out      = r_data_out;
    assign o_ce          = r_ce;
    assign o_sum_ce      = r_sum_ce;
    assign o_last_sample = r_last_sample;
    assign o_sum_ff      = r_sum_ff;

endmodule

// File: tb/tb_average_filter.sv
module tb_average_filter;

    localparam int DW = 8;

    logic                 clk;
    logic                 reset_n;
    logic                 i_ce;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;
    logic                 o_ce;
    logic                 o_sum_ce;
    logic signed [DW-1:0] o_last_sample;
    logic signed [DW:0]   o_sum_ff;

    int total;
    int bad;

    average_filter #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_ce          (i_ce),
        .data_in       (data_in),
        .data_out      (data_out),
        .o_ce          (o_ce),
        .o_sum_ce      (o_sum_ce),
        .o_last_sample (o_last_sample),
        .o_sum_ff      (o_sum_ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: act=%0d req=%0d", nm, act, req);
        end
    endtask

    // Present one sample for a single clock, then check stage 1 and stage 2
    // on the following two falling edges.
    task automatic send(input int x, input int exp_sum, input int exp_out, input string nm);
        @(negedge clk);
        i_ce    = 1'b1;
        data_in = DW'(x);
        @(negedge clk);
        i_ce    = 1'b0;
        data_in = 8'sh5a;
        chk({nm, "/sum_ce"}, int'(o_sum_ce), 1);
        chk({nm, "/sum"},    int'(o_sum_ff), exp_sum);
        chk({nm, "/last"},   int'(o_last_sample), x);
        @(negedge clk);
        chk({nm, "/ce"},     int'(o_ce), 1);
        chk({nm, "/out"},    int'(data_out), exp_out);
    endtask

    typedef struct {
        int x;
        int exp_sum;
        int exp_out;
    } vec_t;

    vec_t vecs [19];

    initial begin
        total = 0;
        bad   = 0;

        // Hand-computed sequence; history is 10 from the latency prime.
        vecs[0]  = '{ -20,  -10,   -5};
        vecs[1]  = '{  30,   10,    5};
        vecs[2]  = '{ -40,  -10,   -5};
        vecs[3]  = '{  50,   10,    5};
        vecs[4]  = '{   0,   50,   25};
        vecs[5]  = '{ 100,  100,   50};
        vecs[6]  = '{-127,  -27,  -14};
        vecs[7]  = '{ 127,    0,    0};
        vecs[8]  = '{ -60,   67,   33};
        vecs[9]  = '{ 100,   40,   20};
        vecs[10] = '{-127,  -27,  -14};
        vecs[11] = '{  -1, -128,  -64};
        vecs[12] = '{   0,   -1,   -1};
        vecs[13] = '{-128, -128,  -64};
        vecs[14] = '{-128, -256, -128};
        vecs[15] = '{ 127,   -1,   -1};
        vecs[16] = '{ 127,  254,  127};
        vecs[17] = '{   1,  128,   64};
        vecs[18] = '{ 127,  128,   64};

        // Reset state, checked without any clock edge.
        reset_n = 1'b0;
        i_ce    = 1'b0;
        data_in = '0;
        #2;
        chk("rst/ce",     int'(o_ce), 0);
        chk("rst/out",    int'(data_out), 0);
        chk("rst/sum_ce", int'(o_sum_ce), 0);
        chk("rst/last",   int'(o_last_sample), 0);
        chk("rst/sum",    int'(o_sum_ff), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Latency: a single i_ce cycle with x[0]=10, history zero.
        i_ce    = 1'b1;
        data_in = 8'sd10;
        @(negedge clk);
        i_ce    = 1'b0;
        chk("lat/c1_sum_ce", int'(o_sum_ce), 1);
        chk("lat/c1_ce",     int'(o_ce), 0);
        chk("lat/c1_sum",    int'(o_sum_ff), 10);
        @(negedge clk);
        chk("lat/c2_sum_ce", int'(o_sum_ce), 0);
        chk("lat/c2_ce",     int'(o_ce), 1);
        chk("lat/c2_out",    int'(data_out), 5);
        @(negedge clk);
        chk("lat/c3_sum_ce", int'(o_sum_ce), 0);
        chk("lat/c3_ce",     int'(o_ce), 0);

        // Signed sequence and rounding corners.
        for (int i = 0; i < 19; i++) begin
            send(vecs[i].x, vecs[i].exp_sum, vecs[i].exp_out, $sformatf("vec%0d", i));
        end

        // Idle hold: several clocks with i_ce low and junk on data_in.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            data_in = DW'(8'h80 + k);
            chk("idle/ce",   int'(o_ce), 0);
            chk("idle/out",  int'(data_out), 64);
            chk("idle/last", int'(o_last_sample), 127);
        end
        send(-1, 126, 63, "after_idle");

        // Back-to-back burst at full rate, then reset while the pipe is full.
        @(negedge clk);
        i_ce    = 1'b1;
        data_in = 8'sd20;
        @(negedge clk);
        data_in = 8'sd40;
        chk("burst/sum0", int'(o_sum_ff), 19);
        @(negedge clk);
        data_in = 8'sd60;
        chk("burst/sum1", int'(o_sum_ff), 60);
        chk("burst/ce0",  int'(o_ce), 1);
        chk("burst/out0", int'(data_out), 9);
        @(negedge clk);
        data_in = 8'sd80;
        chk("burst/sum2", int'(o_sum_ff), 100);
        chk("burst/ce1",  int'(o_ce), 1);
        chk("burst/out1", int'(data_out), 30);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst/ce",     int'(o_ce), 0);
        chk("mrst/out",    int'(data_out), 0);
        chk("mrst/sum_ce", int'(o_sum_ce), 0);
        chk("mrst/last",   int'(o_last_sample), 0);
        chk("mrst/sum",    int'(o_sum_ff), 0);
        @(negedge clk);
        i_ce    = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst/no_ce",     int'(o_ce), 0);
            chk("mrst/no_sum_ce", int'(o_sum_ce), 0);
        end
        send(40, 40, 20, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
